cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 116 +++++++++++
 tb/tb_cbus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants one of NUM_REQ requesters ownership of the shared memory
// bus for a whole burst. Selection is round-robin or fixed priority.
package cbus_arbiter_pkg;
    typedef enum logic [2:0] {MLEN1, MLEN2, MLEN4, MLEN8, MLEN16} cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter bit  RR_EN   = 1'b1,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  cbus_req_t     ireqs [NUM_REQ],
    output cbus_resp_t    iresps [NUM_REQ],
    output cbus_req_t     oreq,
    input  cbus_resp_t    oresp,
    output logic          busy,
    output logic [IW-1:0] grant_id
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [7:0]    beat_q, beat_d;
    logic [IW-1:0] winner;
    logic [IW-1:0] sel;
    logic          any_valid;
    int            idx;

    // Scan downward so the candidate closest to the scan start is the last one written.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = RR_EN ? int'(rr_q) + k : k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IW'(idx);
            if (ireqs[sel].valid) begin
                winner    = sel;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        oreq    = '0;
        busy    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) iresps[j] = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_BUSY;
                    grant_d = winner;
                    beat_d  = '0;
                end
            end
            ST_BUSY: begin
                busy            = 1'b1;
                oreq            = ireqs[grant_q];
                iresps[grant_q] = oresp;
                if (oresp.ready && (beat_q != 8'hFF)) beat_d = beat_q + 8'd1;
                // Completion cycle never grants; the next arbitration happens from IDLE.
                if (oresp.ready && oresp.last) begin
                    state_d = ST_IDLE;
                    rr_d    = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a round-robin and a fixed-priority instance share stimulus;
// outputs are compared every cycle against a transaction-level reference model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int NR = 2;

    logic       clk;
    logic       resetn;
    cbus_req_t  ireqs [NR];
    cbus_resp_t oresp;

    cbus_resp_t iresps_rr [NR];
    cbus_req_t  oreq_rr;
    logic       busy_rr;
    logic [0:0] grant_rr;
    cbus_resp_t iresps_fx [NR];
    cbus_req_t  oreq_fx;
    logic       busy_fx;
    logic [0:0] grant_fx;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the bus, and the round-robin start point.
    bit m_busy;
    int m_gid, m_gid_fx, m_rr;

    cbus_arbiter #(.NUM_REQ(NR), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps_rr),
        .oreq(oreq_rr), .oresp(oresp), .busy(busy_rr), .grant_id(grant_rr));

    cbus_arbiter #(.NUM_REQ(NR), .RR_EN(1'b0)) dut_fx (
        .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps_fx),
        .oreq(oreq_fx), .oresp(oresp), .busy(busy_fx), .grant_id(grant_fx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_busy   = 1'b0;
        m_gid    = 0;
        m_gid_fx = 0;
        m_rr     = 0;
    endfunction

    // Round-robin winner: valid requester at the smallest forward distance from m_rr.
    function automatic int pick_rr();
        int best = -1;
        int bestd = NR;
        for (int i = 0; i < NR; i++)
            if (ireqs[i].valid && ((i - m_rr + NR) % NR) < bestd) begin
                bestd = (i - m_rr + NR) % NR;
                best  = i;
            end
        return best;
    endfunction

    function automatic int pick_fx();
        for (int i = 0; i < NR; i++) if (ireqs[i].valid) return i;
        return -1;
    endfunction

    function automatic void model_edge();
        if (!resetn) begin
            m_reset();
        end else if (m_busy) begin
            if (oresp.ready && oresp.last) begin
                m_busy = 1'b0;
                m_rr   = (m_gid + 1) % NR;
            end
        end else if (pick_fx() >= 0) begin
            m_gid    = pick_rr();
            m_gid_fx = pick_fx();
            m_busy   = 1'b1;
        end
    endfunction

    task automatic check_outputs(input string tag);
        cbus_req_t  e_req;
        cbus_resp_t e_rsp;
        e_req = m_busy ? ireqs[m_gid[0]] : '0;
        chk({tag, ".busy"},  128'(busy_rr),  128'(m_busy));
        chk({tag, ".grant"}, 128'(grant_rr), 128'(m_gid));
        chk({tag, ".oreq"},  128'(oreq_rr),  128'(e_req));
        for (int j = 0; j < NR; j++) begin
            e_rsp = (m_busy && j == m_gid) ? oresp : '0;
            chk($sformatf("%s.iresps%0d", tag, j), 128'(iresps_rr[j]), 128'(e_rsp));
        end
        chk({tag, ".fx_busy"},  128'(busy_fx),  128'(m_busy));
        chk({tag, ".fx_grant"}, 128'(grant_fx), 128'(m_gid_fx));
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic cbus_req_t rand_req(input bit v);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = 1'($urandom);
        r.size     = 3'($urandom);
        r.addr     = $urandom;
        r.strobe   = 4'($urandom);
        r.data     = $urandom;
        r.len      = cbus_len_t'($urandom_range(0, 4));
        return r;
    endfunction

    task automatic burst(input string tag, input int nbeats);
        for (int b = 1; b <= nbeats; b++) begin
            oresp.ready = 1'b1;
            oresp.last  = (b == nbeats);
            oresp.data  = $urandom;
            step(tag);
        end
        oresp = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m_reset();
        step("rst");
        resetn = 1'b1;
        step("rst_rel");
    endtask

    initial begin
        resetn = 1'b0;
        oresp  = '0;
        for (int i = 0; i < NR; i++) ireqs[i] = '0;
        m_reset();
        #1;
        step("reset");
        step("reset");
        resetn = 1'b1;
        step("idle");

        // Spurious completion while idle must not be forwarded or change state.
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
        step("spur");
        step("spur");
        chk("spur_busy",  128'(busy_rr), 128'(0));
        chk("spur_resp0", 128'(iresps_rr[0]), 128'(0));
        oresp = '0;
        step("spur_end");

        // Single 16-beat DCache read.
        ireqs[1]          = rand_req(1'b1);
        ireqs[1].is_write = 1'b0;
        ireqs[1].addr     = 32'h8000_0040;
        ireqs[1].len      = MLEN16;
        step("rd_arb");
        chk("rd_busy",  128'(busy_rr),  128'(1));
        chk("rd_grant", 128'(grant_rr), 128'(1));
        burst("rd", 16);
        ireqs[1].valid = 1'b0;
        chk("rd_done", 128'(busy_rr), 128'(0));
        step("rd_idle");

        // Both valid right after reset: 0 first, 1 after one idle cycle.
        do_reset();
        ireqs[0] = rand_req(1'b1);
        ireqs[1] = rand_req(1'b1);
        step("sim_arb0");
        chk("sim_g0", 128'(grant_rr), 128'(0));
        burst("sim_b0", 4);
        chk("sim_gap", 128'(busy_rr), 128'(0));
        step("sim_arb1");
        chk("sim_g1", 128'(grant_rr), 128'(1));
        chk("sim_b1", 128'(busy_rr),  128'(1));
        burst("sim_b1", 4);

        // Three contended transactions: RR gives 0,1,0; fixed gives 0,0,0.
        step("fair_arb0");
        chk("fair_rr0", 128'(grant_rr), 128'(0));
        chk("fair_fx0", 128'(grant_fx), 128'(0));
        burst("fair_t0", 2);
        step("fair_arb1");
        chk("fair_rr1", 128'(grant_rr), 128'(1));
        chk("fair_fx1", 128'(grant_fx), 128'(0));
        burst("fair_t1", 2);
        step("fair_arb2");
        chk("fair_rr2", 128'(grant_rr), 128'(0));
        chk("fair_fx2", 128'(grant_fx), 128'(0));
        burst("fair_t2", 2);
        ireqs[0].valid = 1'b0;
        ireqs[1].valid = 1'b0;
        step("fair_idle");

        // Owner drops valid at beat 5; grant held until last.
        ireqs[0].valid = 1'b1;
        step("drop_arb");
        ireqs[1].valid = 1'b1;
        for (int b = 1; b <= 16; b++) begin
            if (b == 5) ireqs[0].valid = 1'b0;
            oresp.ready = 1'b1;
            oresp.last  = (b == 16);
            oresp.data  = $urandom;
            if (b == 6) begin
                chk("drop_grant", 128'(grant_rr),      128'(0));
                chk("drop_valid", 128'(oreq_rr.valid), 128'(0));
                chk("drop_busy",  128'(busy_rr),       128'(1));
            end
            step("drop");
        end
        oresp = '0;
        step("drop_arb1");
        chk("drop_next", 128'(grant_rr), 128'(1));
        burst("drop_b1", 2);
        ireqs[1].valid = 1'b0;
        step("drop_idle");

        // Reset at beat 8 of a DCache write burst, ICache pending.
        ireqs[1]          = rand_req(1'b1);
        ireqs[1].is_write = 1'b1;
        ireqs[1].len      = MLEN16;
        step("wr_arb");
        chk("wr_grant", 128'(grant_rr), 128'(1));
        ireqs[0] = rand_req(1'b1);
        burst("wr", 7);
        oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1234_5678};
        #2;
        resetn = 1'b0;
        m_reset();
        #1;
        chk("rst_valid", 128'(oreq_rr.valid), 128'(0));
        chk("rst_busy",  128'(busy_rr),       128'(0));
        chk("rst_resp1", 128'(iresps_rr[1]),  128'(0));
        check_outputs("rst_mid");
        oresp = '0;
        step("rst_hold");
        resetn = 1'b1;
        step("rst_arb");
        chk("rst_g0",    128'(grant_rr), 128'(0));
        chk("rst_gbusy", 128'(busy_rr),  128'(1));
        burst("rst_b", 2);
        ireqs[0] = '0;
        ireqs[1] = '0;
        step("rst_idle");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0) ireqs[i] = rand_req($urandom_range(0, 9) < 7);
            oresp.ready = ($urandom_range(0, 9) < 6);
            oresp.last  = oresp.ready && ($urandom_range(0, 4) == 0);
            oresp.data  = $urandom;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
